// File: rtl/fp_pkg.sv
// Shared constants and types for the fp_add_scheduler slice.
//   XLEN   operand/result width (IEEE-754 single only)
//   EXP_W  exponent field width
//   MAN_W  stored mantissa field width
//   BIAS   exponent bias
//   state_t scheduler FSM states
package fp_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 23;
  localparam int unsigned BIAS  = 127;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

endpackage

// File: rtl/fp_adder.sv
// Combinational IEEE-754 single-precision adder, round-to-nearest-even.
// Handles subnormals, signed zeros, infinities; NaN results are the canonical quiet NaN.
// Ports:
//   a, b    in   XLEN  operands
//   result  out  XLEN  a + b
module fp_adder
  import fp_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result
);

  // hidden bit + stored mantissa + guard/round/sticky
  localparam int unsigned EXT_W = MAN_W + 4;
  localparam logic [XLEN-1:0] QNAN = 32'h7FC0_0000;
  localparam logic [EXP_W-1:0] EXP_MAX = '1;

  logic            swap, sub, sticky, rnd;
  logic            a_nan, b_nan, a_inf, b_inf;
  logic [XLEN-1:0] big, sml;
  logic [9:0]      e_big, e_sml, d, shamt, e_res;
  logic [EXT_W-1:0] m_big, m_sml, m_shf, norm;
  logic [EXT_W:0]  sum;
  logic [4:0]      lz;
  logic [XLEN-2:0] mag;

  always_comb begin
    a_nan = (a[30:23] == EXP_MAX) && (a[22:0] != '0);
    b_nan = (b[30:23] == EXP_MAX) && (b[22:0] != '0);
    a_inf = (a[30:23] == EXP_MAX) && (a[22:0] == '0);
    b_inf = (b[30:23] == EXP_MAX) && (b[22:0] == '0);

    // Order by magnitude so the subtraction below never goes negative.
    swap = b[30:0] > a[30:0];
    big  = swap ? b : a;
    sml  = swap ? a : b;
    sub  = big[31] ^ sml[31];

    // Subnormals use exponent 1 with no hidden bit.
    e_big = (big[30:23] == '0) ? 10'd1 : {2'b00, big[30:23]};
    e_sml = (sml[30:23] == '0) ? 10'd1 : {2'b00, sml[30:23]};
    m_big = {big[30:23] != '0, big[22:0], 3'b000};
    m_sml = {sml[30:23] != '0, sml[22:0], 3'b000};

    d      = e_big - e_sml;
    m_shf  = m_sml >> d;
    sticky = (m_shf << d) != m_sml;
    m_shf[0] = m_shf[0] | sticky;

    sum = sub ? ({1'b0, m_big} - {1'b0, m_shf}) : ({1'b0, m_big} + {1'b0, m_shf});

    lz = 5'(EXT_W);
    for (int i = 0; i < int'(EXT_W); i++) begin
      if (sum[i]) begin
        lz = 5'(int'(EXT_W) - 1 - i);
      end
    end

    shamt = '0;
    if (sum[EXT_W]) begin
      norm  = {sum[EXT_W:2], sum[1] | sum[0]};
      e_res = e_big + 10'd1;
    end else begin
      // Never normalise below exponent 1; what remains is a subnormal.
      shamt = ({5'b00000, lz} > (e_big - 10'd1)) ? (e_big - 10'd1) : {5'b00000, lz};
      norm  = sum[EXT_W-1:0] << shamt;
      e_res = e_big - shamt;
    end

    rnd = norm[2] & (norm[1] | norm[0] | norm[3]);
    // Rounding carry ripples into the exponent field, covering mantissa overflow and
    // subnormal-to-normal promotion.
    mag = {(norm[EXT_W-1] ? e_res[EXP_W-1:0] : {EXP_W{1'b0}}), norm[EXT_W-2:3]}
          + (XLEN-1)'(rnd);

    result = {big[31], mag};
    if (e_res >= 10'd255) begin
      result = {big[31], EXP_MAX, {MAN_W{1'b0}}};
    end
    if (sum == '0) begin
      // Exact cancellation gives +0; -0 + -0 stays -0.
      result = {~sub & big[31], {(XLEN-1){1'b0}}};
    end
    if (a_nan || b_nan || (a_inf && b_inf && sub)) begin
      result = QNAN;
    end else if (a_inf) begin
      result = a;
    end else if (b_inf) begin
      result = b;
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first set request at or after ptr, wrapping.
// Ports:
//   req    in   NREQ  request vector
//   ptr    in   IDW   highest-priority index
//   grant  out  NREQ  one-hot grant (all zero when no request)
//   idx    out  IDW   encoded index of the granted request
//   any    out  1     at least one request present
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  localparam int unsigned IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  int j;

  always_comb begin
    grant = '0;
    idx   = '0;
    j     = 0;
    any   = |req;
    // Walk from farthest to nearest offset so the nearest hit wins.
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % int'(NREQ);
      if (req[j]) begin
        idx = IDW'(j);
      end
    end
    grant[idx] = any;
  end

endmodule

// File: rtl/fp_add_scheduler.sv
// Shares one combinational fp_adder among NREQ requesters with round-robin arbitration,
// operand capture, a registered result and one response port tagged with the requester id.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   req_valid    per-requester request
//   req_a/req_b  packed operands, requester i at [i*XLEN +: XLEN]
//   req_ready    one-hot accept pulse (IDLE only)
//   rsp_valid    result available (RESP)
//   rsp_ready    consumer accepts result
//   rsp_result   registered adder output
//   rsp_id       requester owning rsp_result
//   busy         FSM not in IDLE
module fp_add_scheduler
  import fp_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  localparam int unsigned IDW = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*XLEN-1:0] req_a,
  input  logic [NREQ*XLEN-1:0] req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [XLEN-1:0]      rsp_result,
  output logic [IDW-1:0]       rsp_id,
  output logic                 busy
);

  state_t          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d, id_q, rsp_id_q, gnt_idx;
  logic [XLEN-1:0] op_a_q, op_b_q, rsp_result_q, add_res;
  logic [NREQ-1:0] gnt;
  logic            gnt_any;

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .req  (req_valid),
    .ptr  (rr_ptr_q),
    .grant(gnt),
    .idx  (gnt_idx),
    .any  (gnt_any)
  );

  // Fed only from the captured operands, so requesters may change inputs after accept.
  fp_adder u_add (
    .a     (op_a_q),
    .b     (op_b_q),
    .result(add_res)
  );

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    req_ready = '0;
    unique case (state_q)
      IDLE: begin
        if (gnt_any) begin
          req_ready = gnt;
          state_d   = EXEC;
        end
      end
      EXEC: state_d = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_d  = IDLE;
          rr_ptr_d = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      id_q         <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      rsp_result_q <= '0;
      rsp_id_q     <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      if (state_q == IDLE && gnt_any) begin
        op_a_q <= req_a[gnt_idx*XLEN +: XLEN];
        op_b_q <= req_b[gnt_idx*XLEN +: XLEN];
        id_q   <= gnt_idx;
      end
      if (state_q == EXEC) begin
        rsp_result_q <= add_res;
        rsp_id_q     <= id_q;
      end
    end
  end

  assign rsp_valid  = (state_q == RESP);
  assign busy       = (state_q != IDLE);
  assign rsp_result = rsp_result_q;
  assign rsp_id     = rsp_id_q;

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Scoreboard bench for fp_add_scheduler: expected {id, sum} pushed at each grant,
// popped and compared at each response handshake.
module tb_fp_add_scheduler;

  localparam int NREQ = 4;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] res;
  } rsp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [127:0] req_a, req_b;
  logic [3:0]   req_ready;
  logic         rsp_valid, rsp_ready;
  logic [31:0]  rsp_result;
  logic [1:0]   rsp_id;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_grants = 0;
  int exp_ptr = 0;
  int g_exp;
  int last_grant_cyc = -100;
  bit chk_spacing = 1'b0;
  bit prev_rsp_valid = 1'b0;
  logic [31:0] exp_sum [NREQ];
  rsp_t sb[$];
  rsp_t e_rsp;

  fp_add_scheduler #(
    .NREQ(NREQ)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_result(rsp_result),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      exp_ptr = 0;
      prev_rsp_valid = 1'b0;
      check("rst_ctrl", {23'b0, req_ready, rsp_valid, busy, rsp_id}, 32'h0);
      check("rst_result", rsp_result, 32'h0);
    end else begin
      if (busy) check("ready_while_busy", 32'(req_ready), 32'h0);
      if (req_ready != 4'b0) begin
        g_exp = -1;
        for (int k = NREQ - 1; k >= 0; k--) begin
          if (req_valid[(exp_ptr + k) % NREQ]) g_exp = (exp_ptr + k) % NREQ;
        end
        check("grant", 32'(req_ready), (g_exp >= 0) ? (32'h1 << g_exp) : 32'h0);
        if (g_exp >= 0) sb.push_back({2'(g_exp), exp_sum[g_exp]});
        if (chk_spacing && n_grants > 0) check("accept_spacing", 32'(cyc - last_grant_cyc), 32'd3);
        last_grant_cyc = cyc;
        n_grants++;
      end
      if (rsp_valid && !prev_rsp_valid) check("latency", 32'(cyc - last_grant_cyc), 32'd2);
      if (rsp_valid && sb.size() == 0) begin
        check("rsp_without_op", 32'(rsp_valid), 32'h0);
      end else if (rsp_valid && rsp_ready) begin
        e_rsp = sb.pop_front();
        check("rsp_result", rsp_result, e_rsp.res);
        check("rsp_id", 32'(rsp_id), 32'(e_rsp.id));
        exp_ptr = (int'(e_rsp.id) + 1) % NREQ;
      end
      prev_rsp_valid = rsp_valid;
    end
  end

  // Wait until n more grants have been observed; returns just after a rising edge.
  task automatic wait_grants(input int n);
    int target;
    target = n_grants + n;
    for (int t = 0; t < 80 && n_grants < target; t++) @(posedge clk);
    #1;
    check("grant_timeout", 32'(n_grants < target), 32'h0);
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] s);
    exp_sum[i] = s;
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
  endtask

  task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] s);
    set_op(i, a, b, s);
    req_valid[i] = 1'b1;
    wait_grants(1);
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while ((busy || sb.size() != 0) && t < 60) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("drain_timeout", 32'(t >= 60), 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [31:0] tbl_a [8] = '{32'h3F800000, 32'h80000000, 32'h7F800000, 32'h3F800001,
                             32'h7F7FFFFF, 32'h3F800000, 32'h00000001, 32'h00400000};
  logic [31:0] tbl_b [8] = '{32'hBF800000, 32'h80000000, 32'h3F800000, 32'h33800000,
                             32'h7F7FFFFF, 32'h33800000, 32'h00000001, 32'h00400000};
  logic [31:0] tbl_s [8] = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'h3F800002,
                             32'h7F800000, 32'h3F800000, 32'h00000002, 32'h00800000};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) exp_sum[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: single op from requester 0
    issue(0, 32'h3F800000, 32'h40000000, 32'h40400000);
    wait_done();

    // 2: mixed-sign operands on requester 2
    issue(2, 32'h40A00000, 32'hC0400000, 32'h40000000);
    wait_done();

    // 3: all four request from reset; order 0,1,2,3 then 0 again
    do_reset();
    set_op(0, 32'h3F800000, 32'h40000000, 32'h40400000);
    set_op(1, 32'hBF4CCCCD, 32'hBF800000, 32'hBFE66666);
    set_op(2, 32'h40A00000, 32'hC0400000, 32'h40000000);
    set_op(3, 32'h3F000000, 32'h3E800000, 32'h3F400000);
    req_valid = 4'hF;
    wait_grants(5);
    req_valid = 4'h0;
    wait_done();

    // 4: back-pressure in RESP with a competing request pending
    rsp_ready = 1'b0;
    issue(1, 32'hBF4CCCCD, 32'hBF800000, 32'hBFE66666);
    set_op(3, 32'h3F000000, 32'h3E800000, 32'h3F400000);
    req_valid[3] = 1'b1;
    for (int t = 0; t < 10 && !rsp_valid; t++) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_valid", 32'(rsp_valid), 32'h1);
      check("stall_result", rsp_result, 32'hBFE66666);
      check("stall_id", 32'(rsp_id), 32'h1);
      check("stall_ready", 32'(req_ready), 32'h0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    wait_grants(1);
    req_valid[3] = 1'b0;
    wait_done();

    // 5: reset during EXEC drops the op and clears the pointer
    issue(1, 32'h3F800000, 32'h40000000, 32'h40400000);
    wait_done();
    set_op(2, 32'h40A00000, 32'hC0400000, 32'h40000000);
    req_valid[2] = 1'b1;
    wait_grants(1);
    req_valid[2] = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("no_rsp_after_rst", 32'(rsp_valid), 32'h0);
    end
    set_op(0, 32'h3F800000, 32'h40000000, 32'h40400000);
    set_op(3, 32'h3F000000, 32'h3E800000, 32'h3F400000);
    @(posedge clk);
    #1;
    req_valid = 4'b1001;
    wait_grants(1);
    req_valid[0] = 1'b0;
    wait_grants(1);
    req_valid[3] = 1'b0;
    wait_done();

    // 6: continuous requester 1, one accept every 3 cycles
    chk_spacing = 1'b1;
    set_op(1, 32'hBF4CCCCD, 32'hBF800000, 32'hBFE66666);
    req_valid[1] = 1'b1;
    wait_grants(6);
    req_valid[1] = 1'b0;
    wait_done();
    chk_spacing = 1'b0;

    // Zeros, infinity, overflow, rounding ties and subnormals
    for (int k = 0; k < 8; k++) begin
      issue(k % NREQ, tbl_a[k], tbl_b[k], tbl_s[k]);
      wait_done();
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
